// File: rtl/keypad_pkg.sv
// Shared keypad definitions used by the scanner and by the key entry logic.
// Holds the key code width, the enter code, the entry FSM state type, the
// default idle timeout for a 5 MHz clock and a small key classification helper.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam logic [KEY_CODE_W-1:0] KEY_ENTER     = 4'd11;
  localparam logic [KEY_CODE_W-1:0] KEY_MAX_DIGIT = 4'd9;

  // 5 s of idle time at 5 MHz
  localparam int DEFAULT_TIMEOUT = 25000000;

  typedef enum logic [0:0] {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } entry_state_e;

  // True for the decimal digit codes 0-9
  function automatic logic is_digit(input logic [KEY_CODE_W-1:0] code);
    return (code <= KEY_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/key_entry_if.sv
// Bundle between the keypad scanner, the key entry block and the result
// consumer.
//   new_key/key_code : one-cycle key pulse from the scanner
//   disp_bcd/disp_cnt: live entry for the display path
//   num_valid/num_bcd/num_bin/num_ack : committed result handshake
//   overflow         : pulse when a digit is rejected on a full buffer
//   key_lost         : sticky flag, key dropped while a result was held
// master = key_entry side, slave = scanner/consumer side.
interface key_entry_if
  import keypad_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14
);

  localparam int CNT_W = $clog2(NDIGITS + 1);

  logic                  new_key;
  logic [KEY_CODE_W-1:0] key_code;
  logic [4*NDIGITS-1:0]  disp_bcd;
  logic [CNT_W-1:0]      disp_cnt;
  logic                  num_valid;
  logic [4*NDIGITS-1:0]  num_bcd;
  logic [BIN_W-1:0]      num_bin;
  logic                  num_ack;
  logic                  overflow;
  logic                  key_lost;

  modport master (
    input  new_key, key_code, num_ack,
    output disp_bcd, disp_cnt, num_valid, num_bcd, num_bin, overflow, key_lost
  );

  modport slave (
    output new_key, key_code, num_ack,
    input  disp_bcd, disp_cnt, num_valid, num_bcd, num_bin, overflow, key_lost
  );

endinterface

// File: rtl/key_entry_idle_timer.sv
// Idle timer for a partially typed entry.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the count (an accepted key)
//   enable     : count only while digits are buffered; held at 0 otherwise
//   expire     : high during the cycle the count sits at TIMEOUT-1; the
//                counter wraps to 0 on the following edge
module key_idle_timer
  import keypad_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             expire_s;

  // A clear in the same cycle suppresses expiry: the new key keeps the entry
  always_comb begin
    expire_s = enable && !clear && (cnt_r == LAST);
  end

  // Idle cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear || !enable || (cnt_r == LAST)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign expire = expire_s;

endmodule

// File: rtl/key_entry.sv
// Keypad entry consumer: assembles up to NDIGITS decimal digits into a number,
// commits it on the enter key and offers it in BCD and binary under a
// valid/ack handshake. Partial entries are dropped after TIMEOUT idle clocks.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : key_entry_if master (key input, display, result handshake,
//                overflow pulse, key_lost flag)
module key_entry
  import keypad_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic         clk,
  input logic         reset,
  key_entry_if.master bus
);

  localparam int CNT_W = $clog2(NDIGITS + 1);
  localparam int BCD_W = 4 * NDIGITS;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NDIGITS);

  entry_state_e     state_r;
  logic [BCD_W-1:0] disp_bcd_r;
  logic [CNT_W-1:0] disp_cnt_r;
  logic [BIN_W-1:0] bin_acc_r;
  logic             num_valid_r;
  logic [BCD_W-1:0] num_bcd_r;
  logic [BIN_W-1:0] num_bin_r;
  logic             overflow_r;
  logic             key_lost_r;

  logic digit_key_s;
  logic enter_key_s;
  logic buf_full_s;
  logic buf_empty_s;
  logic key_taken_s;
  logic expire_s;

  // x*10 + d with shifts only; BIN_W is sized so this cannot overflow
  function automatic logic [BIN_W-1:0] mul10_add(input logic [BIN_W-1:0] x,
                                                 input logic [KEY_CODE_W-1:0] d);
    return (x << 2'd3) + (x << 2'd1) + {{(BIN_W-KEY_CODE_W){1'b0}}, d};
  endfunction

  // Key classification and "accepted key" for the idle timer
  always_comb begin
    digit_key_s = bus.new_key && is_digit(bus.key_code);
    enter_key_s = bus.new_key && (bus.key_code == KEY_ENTER);
    buf_full_s  = (disp_cnt_r == MAX_CNT);
    buf_empty_s = (disp_cnt_r == {CNT_W{1'b0}});
    key_taken_s = (state_r == ENTRY) &&
                  ((digit_key_s && !buf_full_s) || (enter_key_s && !buf_empty_s));
  end

  key_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .clear (key_taken_s),
    .enable(!buf_empty_s),
    .expire(expire_s)
  );

  // Entry/hold state machine with accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ENTRY;
      disp_bcd_r  <= {BCD_W{1'b0}};
      disp_cnt_r  <= {CNT_W{1'b0}};
      bin_acc_r   <= {BIN_W{1'b0}};
      num_valid_r <= 1'b0;
      num_bcd_r   <= {BCD_W{1'b0}};
      num_bin_r   <= {BIN_W{1'b0}};
      overflow_r  <= 1'b0;
      key_lost_r  <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      case (state_r)
        ENTRY: begin
          overflow_r <= digit_key_s && buf_full_s;
          // A key in the expiry cycle wins over the timeout discard
          if (digit_key_s && !buf_full_s) begin
            disp_bcd_r <= {disp_bcd_r[BCD_W-5:0], bus.key_code};
            bin_acc_r  <= mul10_add(bin_acc_r, bus.key_code);
            disp_cnt_r <= disp_cnt_r + CNT_W'(1);
          end else if (enter_key_s && !buf_empty_s) begin
            num_bcd_r   <= disp_bcd_r;
            num_bin_r   <= bin_acc_r;
            num_valid_r <= 1'b1;
            disp_bcd_r  <= {BCD_W{1'b0}};
            disp_cnt_r  <= {CNT_W{1'b0}};
            bin_acc_r   <= {BIN_W{1'b0}};
            state_r     <= HOLD;
          end else if (expire_s) begin
            disp_bcd_r <= {BCD_W{1'b0}};
            disp_cnt_r <= {CNT_W{1'b0}};
            bin_acc_r  <= {BIN_W{1'b0}};
          end
        end
        HOLD: begin
          // Ack clears key_lost even if a key lands in the same cycle
          if (bus.num_ack) begin
            num_valid_r <= 1'b0;
            key_lost_r  <= 1'b0;
            state_r     <= ENTRY;
          end else if (bus.new_key) begin
            key_lost_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ENTRY;
        end
      endcase
    end
  end

  assign bus.disp_bcd  = disp_bcd_r;
  assign bus.disp_cnt  = disp_cnt_r;
  assign bus.num_valid = num_valid_r;
  assign bus.num_bcd   = num_bcd_r;
  assign bus.num_bin   = num_bin_r;
  assign bus.overflow  = overflow_r;
  assign bus.key_lost  = key_lost_r;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry with a short idle timeout. Expected
// results are queued when enter is pressed and popped when num_valid appears.
module tb_key_entry;

  localparam int NDIGITS = 4;
  localparam int BIN_W   = 14;
  localparam int TIMEOUT = 100;

  typedef struct packed {
    logic [15:0] bcd;
    logic [15:0] bin;
  } result_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  result_t exp_q[$];

  key_entry_if #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) bus ();

  key_entry #(
    .NDIGITS(NDIGITS),
    .BIN_W  (BIN_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    bus.new_key  = 1'b1;
    bus.key_code = code;
    tick();
    bus.new_key  = 1'b0;
    bus.key_code = 4'd0;
  endtask

  task automatic ack();
    bus.num_ack = 1'b1;
    tick();
    bus.num_ack = 1'b0;
  endtask

  // Wait (bounded) for num_valid, then compare against the scoreboard head
  task automatic wait_result();
    int n;
    result_t e;
    n = 0;
    while (!bus.num_valid && n < 20) begin
      tick();
      n++;
    end
    check_value("valid_seen", 32'(bus.num_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check_value("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_value("num_bcd", 32'(bus.num_bcd), 32'(e.bcd));
      check_value("num_bin", 32'(bus.num_bin), 32'(e.bin));
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.new_key  = 1'b0;
    bus.key_code = 4'd0;
    bus.num_ack  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_value("rst_disp_bcd", 32'(bus.disp_bcd), 32'h0);
    check_value("rst_disp_cnt", 32'(bus.disp_cnt), 32'd0);
    check_value("rst_valid", 32'(bus.num_valid), 32'd0);
    check_value("rst_lost", 32'(bus.key_lost), 32'd0);

    // 1,2,3 enter
    press(4'd1);
    check_value("d1", 32'(bus.disp_bcd), 32'h0001);
    press(4'd2);
    check_value("d12", 32'(bus.disp_bcd), 32'h0012);
    press(4'd3);
    check_value("d123", 32'(bus.disp_bcd), 32'h0123);
    check_value("cnt3", 32'(bus.disp_cnt), 32'd3);
    exp_q.push_back('{bcd: 16'h0123, bin: 16'd123});
    press(4'd11);
    check_value("valid_lat1", 32'(bus.num_valid), 32'd1);
    check_value("disp_clr", 32'(bus.disp_bcd), 32'h0);
    check_value("cnt_clr", 32'(bus.disp_cnt), 32'd0);
    wait_result();
    ack();
    check_value("ack_valid", 32'(bus.num_valid), 32'd0);
    check_value("ack_keep_bcd", 32'(bus.num_bcd), 32'h0123);

    // 9,9,9,9,7 enter: overflow on the 7
    for (int i = 0; i < 4; i++) begin
      press(4'd9);
      check_value("no_ovf", 32'(bus.overflow), 32'd0);
    end
    press(4'd7);
    check_value("ovf_pulse", 32'(bus.overflow), 32'd1);
    check_value("ovf_buf", 32'(bus.disp_bcd), 32'h9999);
    tick();
    check_value("ovf_drop", 32'(bus.overflow), 32'd0);
    exp_q.push_back('{bcd: 16'h9999, bin: 16'd9999});
    press(4'd11);
    wait_result();
    for (int i = 0; i < 3; i++) tick();
    check_value("hold_valid", 32'(bus.num_valid), 32'd1);
    check_value("hold_bin", 32'(bus.num_bin), 32'd9999);
    ack();
    check_value("ack2_valid", 32'(bus.num_valid), 32'd0);

    // Empty enter and ignored codes
    press(4'd11);
    check_value("empty_enter", 32'(bus.num_valid), 32'd0);
    press(4'd10);
    press(4'd15);
    check_value("ign_disp", 32'(bus.disp_bcd), 32'h0);
    check_value("ign_cnt", 32'(bus.disp_cnt), 32'd0);
    check_value("ign_ovf", 32'(bus.overflow), 32'd0);
    check_value("ign_valid", 32'(bus.num_valid), 32'd0);

    // Keys during hold; ack together with key 8
    press(4'd6);
    exp_q.push_back('{bcd: 16'h0006, bin: 16'd6});
    press(4'd11);
    wait_result();
    press(4'd5);
    check_value("lost_set", 32'(bus.key_lost), 32'd1);
    check_value("lost_valid", 32'(bus.num_valid), 32'd1);
    bus.num_ack  = 1'b1;
    bus.new_key  = 1'b1;
    bus.key_code = 4'd8;
    tick();
    bus.num_ack  = 1'b0;
    bus.new_key  = 1'b0;
    bus.key_code = 4'd0;
    check_value("lost_clr", 32'(bus.key_lost), 32'd0);
    check_value("lost_ack_valid", 32'(bus.num_valid), 32'd0);
    check_value("lost_cnt", 32'(bus.disp_cnt), 32'd0);
    check_value("lost_disp", 32'(bus.disp_bcd), 32'h0);

    // Idle timeout
    press(4'd4);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check_value("to_before", 32'(bus.disp_cnt), 32'd1);
    tick();
    check_value("to_expired", 32'(bus.disp_cnt), 32'd0);
    press(4'd4);
    for (int i = 0; i < TIMEOUT - 2; i++) tick();
    press(4'd6);
    check_value("to_kept", 32'(bus.disp_bcd), 32'h0046);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check_value("to_kept2", 32'(bus.disp_cnt), 32'd2);
    tick();
    check_value("to_expired2", 32'(bus.disp_cnt), 32'd0);

    // Reset mid-entry
    press(4'd3);
    press(4'd7);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_value("rst2_disp", 32'(bus.disp_bcd), 32'h0);
    check_value("rst2_cnt", 32'(bus.disp_cnt), 32'd0);
    check_value("rst2_bcd", 32'(bus.num_bcd), 32'h0);
    check_value("rst2_bin", 32'(bus.num_bin), 32'd0);
    check_value("rst2_valid", 32'(bus.num_valid), 32'd0);
    press(4'd2);
    exp_q.push_back('{bcd: 16'h0002, bin: 16'd2});
    press(4'd11);
    wait_result();
    ack();

    check_value("sb_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
